writeback_select: RTL

WRITEBACK_SELECT -- requirements
Module: writeback_select

---
 rtl/writeback_select_pkg.sv | 24 ++
 rtl/writeback_select_load_extend.sv | 32 +++
 rtl/writeback_select.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/writeback_select_pkg.sv
// ==[ writeback_select_pkg : shared FSM state, load formats, source indices | rev 1.0 ]==
`default_nettype none

package writeback_select_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  localparam logic [2:0] FMT_LB  = 3'b000;
  localparam logic [2:0] FMT_LH  = 3'b001;
  localparam logic [2:0] FMT_LW  = 3'b010;
  localparam logic [2:0] FMT_LBU = 3'b100;
  localparam logic [2:0] FMT_LHU = 3'b101;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;

endpackage

`default_nettype wire

// File: rtl/writeback_select_load_extend.sv
// ==[ load_extend : combinational byte/halfword select with sign/zero extension | rev 1.0 ]==
`default_nettype none

module load_extend
  import writeback_select_pkg::*;
#(
  parameter int Data_Width = 32
) (
  input  logic [Data_Width-1:0] i_word,
  input  logic [2:0]            i_fmt,
  input  logic [1:0]            i_offset,
  output logic [Data_Width-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_offset, 3'b000} +: 8];
    w_half = i_word[{i_offset[1], 4'b0000} +: 16];
    case (i_fmt)
      FMT_LB:  o_result = {{(Data_Width-8){w_byte[7]}}, w_byte};
      FMT_LH:  o_result = {{(Data_Width-16){w_half[15]}}, w_half};
      FMT_LBU: o_result = {{(Data_Width-8){1'b0}}, w_byte};
      FMT_LHU: o_result = {{(Data_Width-16){1'b0}}, w_half};
      default: o_result = i_word;  // LW and unlisted codes: full word
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_select.sv
// ==[ writeback_select : result source select and register writeback | rev 1.0 ]==
// ==[ Optional macro WB_TIMEOUT_EN adds a memory-wait timeout with MemErr pulse ]==
`default_nettype none

module writeback_select
  import writeback_select_pkg::*;
#(
  parameter int Data_Width = 32,
  parameter int Num_Src    = 4,
  parameter int Mem_Src    = SRC_MEM,
  parameter int Timeout    = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic [$clog2(Num_Src)-1:0]    SrcSel,
  input  logic [Num_Src*Data_Width-1:0] SrcData,
  input  logic [2:0]                    LoadFmt,
  input  logic [1:0]                    ByteOffset,
  input  logic [4:0]                    RdAddr,
  input  logic                          RegWriteIn,
  input  logic                          MemValid,
  output logic [Data_Width-1:0]         WriteData,
  output logic [4:0]                    WriteAddr,
  output logic                          WriteEn,
  output logic                          MemErr
);

  wb_state_e             state_q, state_d;
  logic [Data_Width-1:0] wdata_q, wdata_d;
  logic [4:0]            waddr_q, waddr_d;
  logic                  wen_q, wen_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic [2:0]            fmt_q, fmt_d;
  logic [1:0]            off_q, off_d;

  logic [Data_Width-1:0] w_sel_word;
  logic [Data_Width-1:0] w_mem_word;
  logic [Data_Width-1:0] w_ext_word;
  logic [2:0]            w_ext_fmt;
  logic [1:0]            w_ext_off;
  logic                  w_is_mem;
  int                    w_eff_sel;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = (Timeout > 1) ? $clog2(Timeout + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Timeout - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Out-of-range selects fall back to slot 0, which also decides memory-ness.
  always_comb begin
    w_eff_sel  = 0;
    w_sel_word = SrcData[Data_Width-1:0];
    for (int i = 0; i < Num_Src; i++) begin
      if (int'(SrcSel) == i) begin
        w_eff_sel  = i;
        w_sel_word = SrcData[i*Data_Width +: Data_Width];
      end
    end
  end

  assign w_is_mem   = (w_eff_sel == Mem_Src);
  assign w_mem_word = SrcData[Mem_Src*Data_Width +: Data_Width];
  assign w_ext_fmt  = (state_q == IDLE) ? LoadFmt    : fmt_q;
  assign w_ext_off  = (state_q == IDLE) ? ByteOffset : off_q;

  load_extend #(
    .Data_Width (Data_Width)
  ) u_load_extend (
    .i_word   (w_mem_word),
    .i_fmt    (w_ext_fmt),
    .i_offset (w_ext_off),
    .o_result (w_ext_word)
  );

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    wen_d   = 1'b0;
    rd_d    = rd_q;
    rw_d    = rw_q;
    fmt_d   = fmt_q;
    off_d   = off_q;
`ifdef WB_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (InValid) begin
          if (!w_is_mem) begin
            wdata_d = w_sel_word;
            waddr_d = RdAddr;
            wen_d   = RegWriteIn && (RdAddr != 5'd0);
          end else if (MemValid) begin
            wdata_d = w_ext_word;
            waddr_d = RdAddr;
            wen_d   = RegWriteIn && (RdAddr != 5'd0);
          end else begin
            rd_d    = RdAddr;
            rw_d    = RegWriteIn;
            fmt_d   = LoadFmt;
            off_d   = ByteOffset;
            state_d = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (MemValid) begin
          wdata_d = w_ext_word;
          waddr_d = rd_q;
          wen_d   = rw_q && (rd_q != 5'd0);
          state_d = IDLE;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wdata_q <= '0;
      waddr_q <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      fmt_q   <= '0;
      off_q   <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      fmt_q   <= fmt_d;
      off_q   <= off_d;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign InReady   = (state_q == IDLE);
  assign WriteData = wdata_q;
  assign WriteAddr = waddr_q;
  assign WriteEn   = wen_q;
`ifdef WB_TIMEOUT_EN
  assign MemErr    = err_q;
`else
  assign MemErr    = 1'b0;
`endif

endmodule

`default_nettype wire
